// File: rtl/snn_sched_pkg.sv
// Shared types and default sizing for the SNN step scheduler and its delay line.
// Holds the step FSM encoding and a clog2 helper that never yields a zero width.
package snn_sched_pkg;

    localparam int DEF_NUM_NEURONS = 8;
    localparam int DEF_NUM_INPUTS  = 8;
    localparam int DEF_DELAY_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RSP = 3'd3,
        DONE     = 3'd4
    } sched_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_step_scheduler_if.sv
// Request/response link between the step scheduler (master) and the shared neuron update unit (slave).
// Request side is valid/ready; the response is a single-cycle valid for the one outstanding neuron.
interface snn_step_scheduler_if
    import snn_sched_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS
);

    localparam int IDX_W = clog2_min1(NUM_NEURONS);

    logic                  upd_valid;
    logic                  upd_ready;
    logic [IDX_W-1:0]      upd_idx;
    logic [NUM_INPUTS-1:0] upd_spikes;
    logic                  rsp_valid;
    logic                  rsp_spike;

    modport master (
        output upd_valid, upd_idx, upd_spikes,
        input  upd_ready, rsp_valid, rsp_spike
    );

    modport slave (
        input  upd_valid, upd_idx, upd_spikes,
        output upd_ready, rsp_valid, rsp_spike
    );

endinterface

// File: rtl/spike_delay_line.sv
// Per-step spike history ring; dout_o is combinational from the current ring and pointer.
// No backpressure: one slot is written and the pointer advances on every wr_en_i.
module spike_delay_line
    import snn_sched_pkg::*;
#(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int DELAY_DEPTH = DEF_DELAY_DEPTH,
    localparam int DW         = clog2_min1(DELAY_DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_i,
    input  logic [NUM_INPUTS-1:0]         din_i,
    input  logic [NUM_INPUTS-1:0][DW-1:0] delay_i,
    output logic [NUM_INPUTS-1:0]         dout_o
);

    logic [NUM_INPUTS-1:0] hist_q [DELAY_DEPTH];
    logic [DW-1:0]         wp_q;
    logic [DW-1:0]         wp_d;

    function automatic logic [DW-1:0] slot_of(input logic [DW-1:0] wp, input logic [DW-1:0] d);
        int s;
        s = (int'(wp) + DELAY_DEPTH - int'(d)) % DELAY_DEPTH;
        return DW'(s);
    endfunction

    // Delay 0 bypasses the ring so the current step's spikes are seen without a slot write first.
    always_comb begin
        dout_o = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (delay_i[i] == '0) begin
                dout_o[i] = din_i[i];
            end else begin
                dout_o[i] = hist_q[slot_of(wp_q, delay_i[i])][i];
            end
        end
    end

    always_comb begin
        wp_d = wp_q;
        if (wr_en_i) begin
            wp_d = (wp_q == DW'(DELAY_DEPTH - 1)) ? '0 : wp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            for (int s = 0; s < DELAY_DEPTH; s++) begin
                hist_q[s] <= '0;
            end
        end else begin
            wp_q <= wp_d;
            if (wr_en_i) begin
                hist_q[wp_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/snn_step_scheduler.sv
// Time-shares one neuron update unit across NUM_NEURONS per step; first request 2 cycles after step_start, done 2+2*NUM_NEURONS.
// Requests hold while upd_ready is low; step_start/cfg writes arriving mid-step are dropped and flagged.
module snn_step_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int DELAY_DEPTH = DEF_DELAY_DEPTH,
    localparam int IDX_W      = clog2_min1(NUM_NEURONS),
    localparam int AW         = clog2_min1(NUM_INPUTS),
    localparam int DW         = clog2_min1(DELAY_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_start,
    input  logic [NUM_INPUTS-1:0]   in_spikes,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [DW-1:0]           cfg_delay,
    snn_step_scheduler_if.master    upd,
    output logic [NUM_NEURONS-1:0]  out_spikes,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    output logic                    cfg_err
);

    sched_state_e                  state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NUM_INPUTS-1:0]         in_lat_q, in_lat_d;
    logic [NUM_INPUTS-1:0]         spk_q, spk_d;
    logic [NUM_NEURONS-1:0]        shadow_q, shadow_d;
    logic [NUM_NEURONS-1:0]        out_q, out_d;
    logic                          overrun_q, overrun_d;
    logic                          cfg_err_q, cfg_err_d;
    logic [NUM_INPUTS-1:0][DW-1:0] delay_q, delay_d;

    logic                          cap_en;
    logic                          addr_ok;
    logic                          cfg_ok;
    logic [NUM_INPUTS-1:0]         delayed;

    // Only a non-power-of-two input count leaves addresses that name no input.
    if ((1 << AW) == NUM_INPUTS) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = (int'(cfg_addr) < NUM_INPUTS);
    end

    assign cfg_ok = cfg_we && (state_q == IDLE) && addr_ok;

    spike_delay_line #(
        .NUM_INPUTS  (NUM_INPUTS),
        .DELAY_DEPTH (DELAY_DEPTH)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (cap_en),
        .din_i   (in_lat_q),
        .delay_i (delay_q),
        .dout_o  (delayed)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_lat_d  = in_lat_q;
        spk_d     = spk_q;
        shadow_d  = shadow_q;
        out_d     = out_q;
        overrun_d = overrun_q;
        cfg_err_d = 1'b0;
        delay_d   = delay_q;
        cap_en    = 1'b0;

        if (cfg_ok) begin
            delay_d[cfg_addr] = cfg_delay;
        end
        if (cfg_we && !cfg_ok) begin
            cfg_err_d = 1'b1;
        end
        if (step_start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (step_start) begin
                    in_lat_d = in_spikes;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en  = 1'b1;
                spk_d   = delayed;
                idx_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (upd.upd_ready) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (upd.rsp_valid) begin
                    shadow_d[idx_q] = upd.rsp_spike;
                    if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                        out_d   = shadow_d;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_lat_q  <= '0;
            spk_q     <= '0;
            shadow_q  <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
            delay_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_lat_q  <= in_lat_d;
            spk_q     <= spk_d;
            shadow_q  <= shadow_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
            cfg_err_q <= cfg_err_d;
            delay_q   <= delay_d;
        end
    end

    assign upd.upd_valid  = (state_q == ISSUE);
    assign upd.upd_idx    = idx_q;
    assign upd.upd_spikes = spk_q;
    assign out_spikes     = out_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign overrun        = overrun_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: a table of whole steps plus hand sequences for
// spurious responses and a reset landing mid-step.
module tb_snn_step_scheduler;

    localparam int NN = 8;
    localparam int NI = 8;
    localparam int DD = 4;

    typedef struct {
        logic       rst_before;
        logic       do_cfg;
        logic [2:0] cfg_addr;
        logic [1:0] cfg_delay;
        logic [7:0] spikes;
        logic [7:0] rsp_pat;
        logic [7:0] exp_spk;
        logic [7:0] exp_out;
        int         stall_idx;
        int         stall_cyc;
        int         inj_at;
    } step_vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_start;
    logic [7:0] in_spikes;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [1:0] cfg_delay;
    logic [7:0] out_spikes;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    snn_step_scheduler_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) bus ();

    snn_step_scheduler #(
        .NUM_NEURONS (NN),
        .NUM_INPUTS  (NI),
        .DELAY_DEPTH (DD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_start (step_start),
        .in_spikes  (in_spikes),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_delay  (cfg_delay),
        .upd        (bus),
        .out_spikes (out_spikes),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_upd_valid"},  32'(bus.upd_valid),  0);
        chk({tag, "_upd_idx"},    32'(bus.upd_idx),    0);
        chk({tag, "_upd_spikes"}, 32'(bus.upd_spikes), 0);
        chk({tag, "_out_spikes"}, 32'(out_spikes),     0);
        chk({tag, "_busy"},       32'(busy),           0);
        chk({tag, "_done"},       32'(done),           0);
        chk({tag, "_overrun"},    32'(overrun),        0);
        chk({tag, "_cfg_err"},    32'(cfg_err),        0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full step: the bench plays the update unit, answering one cycle after each acceptance.
    task automatic run_step(input step_vec_t v);
        int t0, k, stall_left, pend_k, inj_chk, seen, extra;
        bit pend, got_done;
        @(negedge clk);
        if (v.do_cfg) begin
            cfg_we    = 1'b1;
            cfg_addr  = v.cfg_addr;
            cfg_delay = v.cfg_delay;
        end
        step_start = 1'b1;
        in_spikes  = v.spikes;
        t0 = cyc; k = 0; stall_left = v.stall_cyc; pend = 0; pend_k = 0;
        got_done = 0; inj_chk = 0; seen = -1;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge clk);
            step_start    = 1'b0;
            cfg_we        = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.upd_ready = 1'b1;
            if (pend) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_spike = v.rsp_pat[pend_k];
                pend = 0;
            end
            if (inj_chk == 2) begin
                chk("cfg_err_pulse_end", 32'(cfg_err), 0);
                inj_chk = 0;
            end
            if (inj_chk == 1) begin
                chk("cfg_err_pulse", 32'(cfg_err), 1);
                chk("overrun_set",   32'(overrun), 1);
                inj_chk = 2;
            end
            if (c == v.inj_at) begin
                step_start = 1'b1;
                cfg_we     = 1'b1;
                cfg_addr   = 3'd0;
                cfg_delay  = 2'd1;
                inj_chk    = 1;
            end
            if (bus.upd_valid) begin
                chk("upd_idx",    32'(bus.upd_idx),    32'(k));
                chk("upd_spikes", 32'(bus.upd_spikes), 32'(v.exp_spk));
                if (seen != k) begin
                    extra = (v.stall_idx >= 0 && k > v.stall_idx) ? v.stall_cyc : 0;
                    chk("issue_cycle", 32'(cyc - t0), 32'(2 + 2 * k + extra));
                    seen = k;
                end
                if (k == v.stall_idx && stall_left > 0) begin
                    bus.upd_ready = 1'b0;
                    stall_left--;
                end else begin
                    pend   = 1;
                    pend_k = k;
                    k++;
                end
            end
            if (done) begin
                got_done = 1;
                extra = (v.stall_idx >= 0) ? v.stall_cyc : 0;
                chk("done_cycle",   32'(cyc - t0),   32'(2 + 2 * NN + extra));
                chk("out_spikes",   32'(out_spikes), 32'(v.exp_out));
                chk("busy_in_done", 32'(busy),       1);
                chk("req_count",    32'(k),          32'(NN));
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL step_timeout: got no done, expected done within 200 cycles");
        end
        @(negedge clk);
        chk("done_pulse", 32'(done),       0);
        chk("busy_idle",  32'(busy),       0);
        chk("out_hold",   32'(out_spikes), 32'(v.exp_out));
    endtask

    step_vec_t tbl [11];
    step_vec_t tail;
    int  k, pend_k;
    bit  pend, hit;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'hA5, 8'hAA, 8'hA5, 8'hAA, -1, 0, -1};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h5A, 8'h0F, 8'h5A, 8'h0F,  3, 3, -1};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h81, 8'h33, 8'h81, 8'h33, -1, 0,  4};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'hC3, 8'h00, 8'hC3, -1, 0, -1};
        tbl[4]  = '{1'b1, 1'b1, 3'd0, 2'd2, 8'h01, 8'h00, 8'h00, 8'h00, -1, 0, -1};
        tbl[5]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'hFF, 8'h00, 8'hFF, -1, 0, -1};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h01, 8'h01, 8'h01, -1, 0, -1};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h01, 8'h80, 8'h00, 8'h80, -1, 0, -1};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h55, 8'h00, 8'h55, -1, 0, -1};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'hAA, 8'h01, 8'hAA, -1, 0, -1};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 2'd0, 8'hFE, 8'h3C, 8'hFE, 8'h3C, -1, 0, -1};

        reset         = 1'b1;
        step_start    = 1'b0;
        in_spikes     = '0;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_delay     = '0;
        bus.upd_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_spike = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("init");

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_step(tbl[i]);
            if (i == 3) begin
                chk("overrun_sticky", 32'(overrun), 1);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    bus.rsp_valid = 1'b1;
                    bus.rsp_spike = 1'b1;
                end
                @(negedge clk);
                bus.rsp_valid = 1'b0;
                chk("spurious_rsp_out",  32'(out_spikes),    32'h0C3);
                chk("spurious_rsp_busy", 32'(busy),          0);
                chk("spurious_rsp_vld",  32'(bus.upd_valid), 0);
            end
        end

        // Reset lands while the response for neuron 5 is outstanding; that response then arrives late.
        @(negedge clk);
        step_start = 1'b1;
        in_spikes  = 8'h01;
        k = 0; pend = 0; pend_k = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            step_start    = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.upd_ready = 1'b1;
            if (pend) begin
                if (pend_k == 5) begin
                    hit = 1;
                end else begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_spike = 1'b0;
                end
                pend = 0;
            end
            if (!hit && bus.upd_valid) begin
                pend   = 1;
                pend_k = k;
                k++;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL rst_reach_idx5: got no acceptance of idx 5, expected one within 100 cycles");
        end
        chk("rst_pre_busy", 32'(busy),        1);
        chk("rst_pre_idx",  32'(bus.upd_idx), 5);
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_spike = 1'b1;
        chk_reset_vals("midrst");
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        chk_reset_vals("latersp");

        // delay_reg[0] was 2 before the reset; a cleared delay passes bit0 straight through.
        tail = '{1'b0, 1'b0, 3'd0, 2'd0, 8'h01, 8'h00, 8'h01, 8'h00, -1, 0, -1};
        run_step(tail);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
